// File: rtl/uds_stream_if.sv
// Row-stream bundle between the conv output buffer and the pooling/upsampling engine.
// The master drives rows and out_ready; the slave (engine) returns result rows and status.
interface uds_stream_if #(
  parameter int COLS = 8,
  parameter int CH   = 8,
  parameter int DW   = 32
);
  localparam int IW = COLS * CH * DW;
  localparam int OW = 2 * IW;

  logic [1:0]    function_mode;
  logic [1:0]    scale_factor;
  logic [IW-1:0] in_data;
  logic          in_sof;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;
  logic          mode_err;

  modport master (
    output function_mode, scale_factor, in_data, in_sof, in_valid, out_ready,
    input  in_ready, out_data, out_valid, frame_done, mode_err
  );

  modport slave (
    input  function_mode, scale_factor, in_data, in_sof, in_valid, out_ready,
    output in_ready, out_data, out_valid, frame_done, mode_err
  );
endinterface

// File: rtl/uds_stream.sv
// Row-streaming 2x2/3x3 stride-2 max/avg pooling or 2x nearest upsampling; result one cycle after the completing row.
// One-deep output register: in_ready drops while a result is stalled or the second upsample beat is pending.
module uds_stream #(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int CH   = 8,
  parameter int DW   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  uds_stream_if.slave bus
);
  localparam int IW = COLS * CH * DW;
  localparam int OW = 2 * IW;
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE = 2'd0, OUT = 2'd1, UP2 = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rc_q, rc_d, rc_eff;
  logic [IW-1:0] r1_q, r1_d, r2_q, r2_d;
  logic [1:0]    fm_q, fm_d, sf_q, sf_d, mode_cur, sf_cur;
  logic [OW-1:0] out_data_q, out_data_d, res;
  logic          frame_done_q, frame_done_d, mode_err_q, mode_err_d;
  logic          acc, first, produce;
  logic [DW-1:0] mx, v, q3;
  logic [DW+1:0] s2;
  logic [DW+3:0] s3;

  function automatic logic [DW-1:0] pix(input logic [IW-1:0] row, input int p, input int c);
    return row[(p*CH+c)*DW +: DW];
  endfunction

  // Row 0 of a frame (including an sof row) uses the live mode inputs; later rows use the latched copy.
  always_comb begin
    acc      = bus.in_valid && bus.in_ready;
    rc_eff   = bus.in_sof ? '0 : rc_q;
    first    = (rc_eff == '0);
    mode_cur = first ? bus.function_mode : fm_q;
    sf_cur   = first ? bus.scale_factor : sf_q;
    if (mode_cur[1])          produce = 1'b1;
    else if (sf_cur == 2'd0)  produce = rc_eff[0];
    else if (sf_cur == 2'd1)  produce = !rc_eff[0] && (rc_eff >= RW'(2));
    else                      produce = 1'b0;
  end

  always_comb begin
    res = '0;
    mx  = '0;
    v   = '0;
    s2  = '0;
    s3  = '0;
    q3  = '0;
    if (mode_cur[1]) begin
      for (int q = 0; q < 2*COLS; q++)
        for (int c = 0; c < CH; c++)
          res[(q*CH+c)*DW +: DW] = pix(bus.in_data, q/2, c);
    end else if (sf_cur == 2'd0) begin
      for (int k = 0; k < COLS/2; k++)
        for (int c = 0; c < CH; c++) begin
          mx = '0;
          s2 = '0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v  = (dr == 0) ? pix(r1_q, 2*k+dc, c) : pix(bus.in_data, 2*k+dc, c);
              mx = (v > mx) ? v : mx;
              s2 = s2 + (DW+2)'(v);
            end
          res[(k*CH+c)*DW +: DW] = mode_cur[0] ? DW'(s2 >> 2) : mx;
        end
    end else if (sf_cur == 2'd1) begin
      for (int k = 0; k < (COLS-1)/2; k++)
        for (int c = 0; c < CH; c++) begin
          mx = '0;
          s3 = '0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
              v  = (dr == 0) ? pix(r2_q, 2*k+dc, c) :
                   (dr == 1) ? pix(r1_q, 2*k+dc, c) : pix(bus.in_data, 2*k+dc, c);
              mx = (v > mx) ? v : mx;
              s3 = s3 + (DW+4)'(v);
            end
          q3 = DW'(s3 / (DW+4)'(9));
          res[(k*CH+c)*DW +: DW] = mode_cur[0] ? q3 : mx;
        end
    end
  end

  always_comb begin
    rc_d         = rc_q;
    r1_d         = r1_q;
    r2_d         = r2_q;
    fm_d         = fm_q;
    sf_d         = sf_q;
    out_data_d   = out_data_q;
    mode_err_d   = mode_err_q;
    frame_done_d = 1'b0;
    if (acc) begin
      rc_d         = (rc_eff == RW'(ROWS-1)) ? '0 : rc_eff + RW'(1);
      r1_d         = bus.in_data;
      r2_d         = r1_q;
      fm_d         = mode_cur;
      sf_d         = sf_cur;
      frame_done_d = (rc_eff == RW'(ROWS-1));
      if (first && !mode_cur[1] && sf_cur[1]) mode_err_d = 1'b1;
      if (produce) out_data_d = res;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acc && produce) begin
      state_d = mode_cur[1] ? UP2 : OUT;
    end else if (bus.out_ready) begin
      case (state_q)
        UP2:     state_d = OUT;
        OUT:     state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // UP2 presents the first upsample beat; OUT then re-presents the same data as the second beat.
  always_comb begin
    bus.out_valid = (state_q != IDLE);
    bus.in_ready  = rst_n && ((state_q == IDLE) || ((state_q == OUT) && bus.out_ready));
  end

  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.mode_err   = mode_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc_q         <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
      fm_q         <= '0;
      sf_q         <= '0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      rc_q         <= rc_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      fm_q         <= fm_d;
      sf_q         <= sf_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      mode_err_q   <= mode_err_d;
    end
  end
endmodule

// File: doc/uds_stream.md
# uds_stream

Parametrised, handshaked successor to the fixed 8x8 up/down-sampling engine. Accepts one feature-map row per beat, performs 2x2/stride-2 or 3x3/stride-2 max/avg pooling or 2x nearest-neighbour upsampling, and emits result rows on a valid/ready output port. Sits between the convolution output buffer and the next-layer input buffer. Frame geometry and pixel depth are set by parameters; mode is latched per frame.

## Interface
- COLS, 8: pixels per input row; even, >= 4
- ROWS, 8: input rows per frame; >= 3
- CH, 8: channels per pixel
- DW, 32: bits per channel value, unsigned
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- function_mode  in  2  [1]=1 upsample, [1]=0 downsample; [0]=0 max, 1 avg (downsample only)
- scale_factor  in  2  downsample window: 0 = 2x2 s2, 1 = 3x3 s2, 2/3 reserved
- in_data  in  COLS*CH*DW  one input row; pixel p, channel c at [(p*CH+c)*DW +: DW]
- in_sof  in  1  marks the first row of a frame; qualified by in_valid
- in_valid / in_ready  in / out  1 / 1  input handshake
- out_data  out  2*COLS*CH*DW  result row, same packing; unused upper pixels are 0
- out_valid / out_ready  out / in  1 / 1  output handshake
- frame_done  out  1  one-cycle pulse after the last row of a frame is accepted
- mode_err  out  1  sticky; set when a frame starts with a reserved mode; cleared only by reset

## Operation
- A beat is accepted when in_valid && in_ready. Row counter rc runs 0..ROWS-1 and wraps to 0. An accepted in_sof forces rc=0 and discards any partial-frame state.
- At rc=0, function_mode and scale_factor are latched and held for the whole frame. Mid-frame input changes are ignored.
- Row buffers R1 (row rc-1) and R2 (row rc-2) update on every accepted row.
- 2x2 mode: on accepting an odd rc, emit one row of COLS/2 pixels. Pixel k covers rows {rc-1, rc} and cols {2k, 2k+1}.
  - max: per-channel unsigned max.
  - avg: floor(sum/4), using a DW+2 bit sum truncated back to DW.
- 3x3 mode: on accepting an even rc >= 2, emit one row of floor((COLS-1)/2) pixels. Pixel k covers rows rc-2..rc and cols 2k..2k+2.
  - avg: exact floor(sum/9), using a DW+4 bit sum. No padding; trailing rows and columns not covered by a full window are dropped.
- Upsample: each accepted row produces two identical output beats of 2*COLS pixels. Output pixel q = input pixel q>>1.
- Reserved scale_factor in downsample: rows are accepted and discarded, no output beats, mode_err is set at rc=0.
- FSM:
  - IDLE: out_valid=0.
  - OUT: result registered, out_valid=1. Goes to IDLE on out_ready, or takes a new result when one arrives in the same cycle.
  - UP2: second upsample beat pending.

## Timing
- Reset values: out_data=0, out_valid=0, frame_done=0, mode_err=0, rc=0, R1=R2=0, FSM=IDLE. in_ready=0 while rst_n=0.
- in_ready = (FSM!=UP2) && (!out_valid || out_ready). This gives full throughput with one-deep output buffering.
- Downsample latency: out_valid rises the cycle after acceptance of the completing row. Data is held stable while out_valid && !out_ready.
- Upsample: first beat the cycle after acceptance. The second beat follows the handshake of the first. in_ready stays low until the second beat is taken.
- Simultaneous output handshake and acceptance of a producing row: the new result loads the next cycle with no bubble.
- frame_done pulses the cycle after acceptance of row rc=ROWS-1. It is independent of out_ready.
- Reset mid-frame: all state returns to reset values and the pending output is lost.

## Test plan
Bench parameters: COLS=4, ROWS=4, CH=1, DW=8 unless noted.
- 2x2 max: rows [1,5,2,8],[3,4,9,0] -> one beat, low pixels [5,9], pixels 2..7 = 0, one cycle after the second accept.
- 2x2 avg, same rows -> [3,4]. All-255 rows -> [255,255] (no overflow).
- 3x3 avg: rows [1,2,3,x],[4,5,6,x],[7,8,9,x],[0,0,0,0] -> one beat [5] after row 2. Row 3 produces nothing. frame_done after row 3.
- Upsample: row [1,2,3,4] with out_ready held low 3 cycles -> beat [1,1,2,2,3,3,4,4] stable for those cycles, then the identical second beat. in_ready=0 until the second beat is taken.
- in_sof asserted on the second row of a 2x2 frame -> first row discarded. Output only after the next accepted row.
- scale_factor=2 at frame start -> no out_valid for the frame, mode_err=1 and stays 1 across later frames. rst_n=0 clears it.
